axi_mem_router_model: RTL and testbench

- Behavioural AXI4 (ID-less) burst memory slave that terminates the NPU's 256-bit AXI master port in simulation.
- Serves DMA read and write bursts from a byte-addressed backing array named `mem`.
- Benches compare array bytes directly by hierarchical reference, for example `mem[dst+j]` against `mem[src+j]`.
- Read and write channels are independent; each channel has one burst outstanding.

---
 rtl/axi_mem_router_model.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_mem_router_model.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_router_model.sv
// Behavioural AXI4 (ID-less) INCR burst memory slave backed by a byte array `mem`.
// Read and write channels run independently, one burst outstanding on each.
module axi_mem_router_model #(
  parameter int unsigned MEM_ADDR_BITS = 21,
  parameter int unsigned DATA_W        = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_axi_awvalid,
  output logic                m_axi_awready,
  input  logic [63:0]         m_axi_awaddr,
  input  logic [7:0]          m_axi_awlen,
  input  logic [2:0]          m_axi_awsize,
  input  logic                m_axi_wvalid,
  output logic                m_axi_wready,
  input  logic [DATA_W-1:0]   m_axi_wdata,
  input  logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_wlast,
  output logic                m_axi_bvalid,
  input  logic                m_axi_bready,
  input  logic                m_axi_arvalid,
  output logic                m_axi_arready,
  input  logic [63:0]         m_axi_araddr,
  input  logic [7:0]          m_axi_arlen,
  input  logic [2:0]          m_axi_arsize,
  output logic                m_axi_rvalid,
  input  logic                m_axi_rready,
  output logic [DATA_W-1:0]   m_axi_rdata,
  output logic                m_axi_rlast
);

  localparam int unsigned AW        = MEM_ADDR_BITS;
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned MEM_BYTES = 1 << MEM_ADDR_BITS;

  typedef logic [7:0] mem_t [MEM_BYTES];

  // Power-up contents: each byte is a fold of its own address so regions differ.
  function automatic mem_t mem_init_f();
    mem_t        m;
    logic [31:0] a;
    for (int unsigned i = 0; i < MEM_BYTES; i++) begin
      a = 32'(i);
      m[AW'(i)] = a[7:0] ^ a[15:8] ^ 8'(a[20:16]);
    end
    return m;
  endfunction

  mem_t mem = mem_init_f();

  // One-hot write states; each bit is also the registered handshake output.
  typedef enum logic [2:0] {
    AW_IDLE = 3'b001,
    W_DATA  = 3'b010,
    B_RESP  = 3'b100
  } w_state_e;

  typedef enum logic [0:0] {
    R_DATA  = 1'b0,
    AR_IDLE = 1'b1
  } r_state_e;

  w_state_e          w_state_q, w_state_d;
  logic [AW-1:0]     aw_addr_q, aw_addr_d;
  logic [7:0]        aw_len_q, aw_len_d;
  logic [2:0]        aw_size_q, aw_size_d;
  logic [7:0]        w_beat_q, w_beat_d;
  logic              w_fire_c;
  logic [AW-1:0]     w_beat_addr_c;

  r_state_e          r_state_q, r_state_d;
  logic [AW-1:0]     ar_addr_q, ar_addr_d;
  logic [7:0]        ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [7:0]        r_beat_q, r_beat_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q;
  logic              r_load_c;
  logic [AW-1:0]     r_load_addr_c;
  logic [7:0]        r_next_c;

  // Address bits above the backing store are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m_axi_awaddr[63:AW], m_axi_araddr[63:AW]};

  assign m_axi_awready = w_state_q[0];
  assign m_axi_wready  = w_state_q[1];
  assign m_axi_bvalid  = w_state_q[2];
  assign m_axi_arready = (r_state_q == AR_IDLE);
  assign m_axi_rvalid  = rvalid_q;
  assign m_axi_rlast   = rlast_q;
  assign m_axi_rdata   = rdata_q;

  assign w_beat_addr_c = aw_addr_q + (AW'(w_beat_q) << aw_size_q);

  // Write channel next-state: AW capture, data beats, response hold.
  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    aw_len_d  = aw_len_q;
    aw_size_d = aw_size_q;
    w_beat_d  = w_beat_q;
    w_fire_c  = 1'b0;
    unique case (w_state_q)
      AW_IDLE: begin
        if (m_axi_awvalid) begin
          w_state_d = W_DATA;
          aw_addr_d = m_axi_awaddr[AW-1:0];
          aw_len_d  = m_axi_awlen;
          aw_size_d = m_axi_awsize;
          w_beat_d  = 8'd0;
        end
      end
      W_DATA: begin
        if (m_axi_wvalid) begin
          w_fire_c = 1'b1;
          w_beat_d = w_beat_q + 8'd1;
          // Whichever of wlast or the beat count comes first closes the burst.
          if (m_axi_wlast || (w_beat_q == aw_len_q)) begin
            w_state_d = B_RESP;
          end
        end
      end
      B_RESP: begin
        if (m_axi_bready) begin
          w_state_d = AW_IDLE;
        end
      end
      default: w_state_d = AW_IDLE;
    endcase
  end

  // Write channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= AW_IDLE;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      w_beat_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_addr_q <= aw_addr_d;
      aw_len_q  <= aw_len_d;
      aw_size_q <= aw_size_d;
      w_beat_q  <= w_beat_d;
    end
  end

  // Strobed byte writes into the backing store; reset never touches it.
  always_ff @(posedge clk) begin
    if (w_fire_c) begin
      for (int unsigned k = 0; k < STRB_W; k++) begin
        if (m_axi_wstrb[k]) begin
          mem[w_beat_addr_c + AW'(k)] <= m_axi_wdata[8*k +: 8];
        end
      end
    end
  end

  // Read channel next-state: beat 0 loads on the AR edge, later beats on rready.
  always_comb begin
    r_state_d     = r_state_q;
    ar_addr_d     = ar_addr_q;
    ar_len_d      = ar_len_q;
    ar_size_d     = ar_size_q;
    r_beat_d      = r_beat_q;
    rvalid_d      = rvalid_q;
    rlast_d       = rlast_q;
    r_load_c      = 1'b0;
    r_load_addr_c = '0;
    r_next_c      = r_beat_q + 8'd1;
    unique case (r_state_q)
      AR_IDLE: begin
        if (m_axi_arvalid) begin
          r_state_d     = R_DATA;
          ar_addr_d     = m_axi_araddr[AW-1:0];
          ar_len_d      = m_axi_arlen;
          ar_size_d     = m_axi_arsize;
          r_beat_d      = 8'd0;
          r_load_c      = 1'b1;
          r_load_addr_c = m_axi_araddr[AW-1:0];
          rvalid_d      = 1'b1;
          rlast_d       = (m_axi_arlen == 8'd0);
        end
      end
      R_DATA: begin
        if (m_axi_rready) begin
          if (rlast_q) begin
            r_state_d = AR_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_beat_d      = r_next_c;
            r_load_c      = 1'b1;
            r_load_addr_c = ar_addr_q + (AW'(r_next_c) << ar_size_q);
            rlast_d       = (r_next_c == ar_len_q);
          end
        end
      end
      default: r_state_d = AR_IDLE;
    endcase
  end

  // Read channel registers; beat bytes are captured from pre-edge memory contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= AR_IDLE;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      r_beat_q  <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_size_q <= ar_size_d;
      r_beat_q  <= r_beat_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      if (r_load_c) begin
        for (int unsigned k = 0; k < STRB_W; k++) begin
          rdata_q[8*k +: 8] <= mem[r_load_addr_c + AW'(k)];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_router_model.sv
// Randomised bench for axi_mem_router_model against a sparse byte-array reference.
module tb_axi_mem_router_model;

  localparam int unsigned MA = 21;
  localparam int unsigned NB = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_axi_awvalid, m_axi_awready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic         m_axi_wvalid, m_axi_wready;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid, m_axi_bready;
  logic         m_axi_arvalid, m_axi_arready;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic         m_axi_rvalid, m_axi_rready;
  logic [255:0] m_axi_rdata;
  logic         m_axi_rlast;

  axi_mem_router_model #(.MEM_ADDR_BITS(MA), .DATA_W(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference store: only bytes written by the bench are held, the rest follow the init rule.
  logic [7:0]   ref_mem [int unsigned];
  logic [255:0] wq_data [$];
  logic [31:0]  wq_strb [$];
  logic [255:0] rd_beats [$];

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int unsigned a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ {3'b000, v[20:16]};
  endfunction

  function automatic int unsigned idx(input logic [63:0] a);
    return 32'(a[MA-1:0]);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [63:0] a);
    int unsigned i;
    i = idx(a);
    if (ref_mem.exists(i)) return ref_mem[i];
    return init_byte(i);
  endfunction

  function automatic logic [255:0] ref_beat(input logic [63:0] start, input int b, input int size);
    logic [63:0]  ba;
    logic [255:0] v;
    ba = start + (64'(b) << size);
    for (int k = 0; k < NB; k++) v[8*k +: 8] = ref_rd(ba + 64'(k));
    return v;
  endfunction

  function automatic logic [255:0] dut_chunk(input logic [63:0] a);
    logic [255:0] v;
    for (int k = 0; k < NB; k++) v[8*k +: 8] = dut.mem[MA'(a + 64'(k))];
    return v;
  endfunction

  task automatic cmp_region(input string tag, input logic [63:0] a, input int nbytes);
    for (int c = 0; c < nbytes; c += NB) begin
      check_val($sformatf("%s_mem_%0h", tag, idx(a + 64'(c))),
                dut_chunk(a + 64'(c)), ref_beat(a + 64'(c), 0, 0));
    end
  endtask

  // Issues one write burst from wq_data/wq_strb; abort_at >= 0 resets before that beat.
  task automatic do_write(input logic [63:0] addr, input int len, input int size,
                          input int last_at, input int b_hold, input int abort_at);
    int          guard;
    logic [63:0] ba;
    m_axi_awvalid = 1'b1;
    m_axi_awaddr  = addr;
    m_axi_awlen   = 8'(len);
    m_axi_awsize  = 3'(size);
    guard = 0;
    while (!m_axi_awready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val("aw_wait", 256'(guard < 50), 256'(1));
    @(negedge clk);
    m_axi_awvalid = 1'b0;
    check_val("aw_ready_drop", 256'(m_axi_awready), 256'(0));
    for (int b = 0; b <= last_at; b++) begin
      if (b == abort_at) begin
        m_axi_wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("abort_awready", 256'(m_axi_awready), 256'(1));
        check_val("abort_wready", 256'(m_axi_wready), 256'(0));
        check_val("abort_bvalid", 256'(m_axi_bvalid), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        m_axi_wvalid = 1'b0;
        @(negedge clk);
      end
      m_axi_wvalid = 1'b1;
      m_axi_wdata  = wq_data[b];
      m_axi_wstrb  = wq_strb[b];
      m_axi_wlast  = (b == last_at);
      check_val("w_ready", 256'(m_axi_wready), 256'(1));
      @(negedge clk);
      ba = addr + (64'(b) << size);
      for (int k = 0; k < NB; k++) begin
        if (wq_strb[b][k]) ref_mem[idx(ba + 64'(k))] = wq_data[b][8*k +: 8];
      end
    end
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
    check_val("b_valid_rise", 256'(m_axi_bvalid), 256'(1));
    check_val("w_ready_off", 256'(m_axi_wready), 256'(0));
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      check_val("b_valid_hold", 256'(m_axi_bvalid), 256'(1));
    end
    m_axi_bready = 1'b1;
    @(negedge clk);
    m_axi_bready = 1'b0;
    check_val("b_valid_fall", 256'(m_axi_bvalid), 256'(0));
    check_val("aw_ready_back", 256'(m_axi_awready), 256'(1));
  endtask

  // Issues one read burst, stalling rready stall_pct% of cycles; beats land in rd_beats.
  task automatic do_read(input logic [63:0] addr, input int len, input int size, input int stall_pct);
    logic [255:0] exp [$];
    logic [255:0] cap;
    int           guard;
    int           beat;
    bit           rr;
    for (int b = 0; b <= len; b++) exp.push_back(ref_beat(addr, b, size));
    rd_beats.delete();
    m_axi_arvalid = 1'b1;
    m_axi_araddr  = addr;
    m_axi_arlen   = 8'(len);
    m_axi_arsize  = 3'(size);
    guard = 0;
    while (!m_axi_arready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val("ar_wait", 256'(guard < 50), 256'(1));
    @(negedge clk);
    m_axi_arvalid = 1'b0;
    beat  = 0;
    guard = 0;
    while (beat <= len && guard < 4000) begin
      check_val("ar_ready_busy", 256'(m_axi_arready), 256'(0));
      check_val("r_valid", 256'(m_axi_rvalid), 256'(1));
      check_val($sformatf("r_data_b%0d", beat), m_axi_rdata, exp[beat]);
      check_val($sformatf("r_last_b%0d", beat), 256'(m_axi_rlast), 256'(beat == len));
      rr = ($urandom_range(0, 99) >= stall_pct);
      m_axi_rready = rr;
      cap = m_axi_rdata;
      @(negedge clk);
      if (rr) begin
        rd_beats.push_back(cap);
        beat++;
      end
      guard++;
    end
    m_axi_rready = 1'b0;
    check_val("r_done", 256'(beat > len), 256'(1));
    check_val("r_valid_fall", 256'(m_axi_rvalid), 256'(0));
    check_val("r_last_fall", 256'(m_axi_rlast), 256'(0));
    check_val("ar_ready_back", 256'(m_axi_arready), 256'(1));
  endtask

  task automatic fill_random(input int nbeats, input bit full_strb);
    wq_data.delete();
    wq_strb.delete();
    for (int b = 0; b < nbeats; b++) begin
      wq_data.push_back({$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom});
      wq_strb.push_back(full_strb ? 32'hFFFF_FFFF : $urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] v;
    logic [63:0]  a;
    int           len, size, last_at;
    m_axi_awvalid = 0; m_axi_awaddr = 0; m_axi_awlen = 0; m_axi_awsize = 0;
    m_axi_wvalid = 0; m_axi_wdata = 0; m_axi_wstrb = 0; m_axi_wlast = 0;
    m_axi_bready = 0; m_axi_arvalid = 0; m_axi_araddr = 0; m_axi_arlen = 0;
    m_axi_arsize = 0; m_axi_rready = 0;
    repeat (3) @(negedge clk);

    // Reset values and power-up contents
    check_val("rst_awready", 256'(m_axi_awready), 256'(1));
    check_val("rst_arready", 256'(m_axi_arready), 256'(1));
    check_val("rst_wready", 256'(m_axi_wready), 256'(0));
    check_val("rst_bvalid", 256'(m_axi_bvalid), 256'(0));
    check_val("rst_rvalid", 256'(m_axi_rvalid), 256'(0));
    check_val("rst_rlast", 256'(m_axi_rlast), 256'(0));
    check_val("rst_rdata", m_axi_rdata, 256'(0));
    check_val("init_10001", 256'(dut.mem[21'h10001]), 256'(init_byte(32'h10001)));
    check_val("init_00005", 256'(dut.mem[21'h00005]), 256'(8'h05));
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat read at 0: byte k holds k
    do_read(64'h0, 0, 5, 0);
    for (int k = 0; k < NB; k++) v[8*k +: 8] = 8'(k);
    check_val("single_beat_bytes", rd_beats[0], v);

    // Eight-beat full-strobe write with B held off for three cycles
    fill_random(8, 1'b1);
    do_write(64'h10000, 7, 5, 7, 3, -1);
    cmp_region("burst", 64'h10000, 256);

    // Partial strobe: only four lanes land
    wq_data.delete(); wq_strb.delete();
    wq_data.push_back({32{8'hAA}});
    wq_strb.push_back(32'h0000_000F);
    do_write(64'h200, 0, 5, 0, 0, -1);
    for (int j = 0; j < 4; j++) check_val("pstrb_hit", 256'(dut.mem[MA'(32'h200 + j)]), 256'(8'hAA));
    check_val("pstrb_miss", 256'(dut.mem[21'h204]), 256'(8'h06));

    // Read with random backpressure: beat n holds bytes 32n..32n+31
    do_read(64'h0, 7, 5, 50);
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < NB; k++) v[8*k +: 8] = 8'(32 * n + k);
      check_val($sformatf("bp_beat%0d", n), rd_beats[n], v);
    end

    // Copy 256 bytes from 0 to 0x10000 through the bus
    do_read(64'h0, 7, 5, 20);
    wq_data = rd_beats;
    wq_strb.delete();
    for (int b = 0; b < 8; b++) wq_strb.push_back(32'hFFFF_FFFF);
    do_write(64'h10000, 7, 5, 7, 0, -1);
    for (int c = 0; c < 8; c++)
      check_val($sformatf("copy_c%0d", c), dut_chunk(64'h10000 + 64'(32 * c)), ref_beat(64'(32 * c), 0, 0));

    // Reset during a write burst keeps the beats already written
    fill_random(8, 1'b1);
    do_write(64'h3000, 7, 5, 7, 0, 2);
    cmp_region("abort", 64'h3000, 256);
    do_read(64'h3000, 3, 5, 10);

    // Random bursts: arbitrary upper address bits, sizes, strobes, early wlast, wrap at top
    for (int t = 0; t < 16; t++) begin
      a = {$urandom, $urandom};
      if (t % 4 == 3) a[MA-1:0] = MA'(32'h1F_FFE0 + $urandom_range(0, 31));
      len     = $urandom_range(0, 7);
      size    = $urandom_range(0, 5);
      last_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
      fill_random(len + 1, 1'b0);
      do_write(a, len, size, last_at, $urandom_range(0, 3), -1);
      cmp_region($sformatf("rnd%0d", t), a, (len << size) + NB);
      do_read(a, len, size, 30);
      do_read({$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 5), 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
